arbitro_contador: RTL and testbench

Round-robin arbiter and sequencer that shares one 6-bit up/down/load counter among `N_REQ` requesters. Each requester posts an operation (increment, decrement, load, no-op) with a req/ack handshake. The block grants one requester at a time and drives the counter's `operacao`/`valor` inputs for exactly one cycle per granted request. It also guards the counter against wrap-around: it rejects increment at the maximum value and decrement at zero, and reports the rejection with `erro`.

---
 rtl/arbitro_contador.sv | 138 +++++++++++++
 tb/tb_arbitro_contador.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_contador.sv
// arbitro_contador
//   Round-robin arbiter/sequencer sharing one W-bit up/down/load counter
//   among N_REQ requesters. Each granted request drives the counter's
//   operacao/valor inputs for exactly one cycle. The request is then
//   acknowledged with a one-cycle ack pulse. Increment at the maximum
//   value and decrement at zero are suppressed and flagged with erro.
//
// Ports
//   clk        system clock, all logic on posedge
//   clr_n      synchronous active-low reset, shared with the counter
//   req        request per requester, held high until its ack
//   op_req     2-bit op per requester (00 inc, 01 dec, 10 load, 11 no-op)
//   valor_req  W-bit load value per requester
//   cont       current counter value, fed back from the counter
//   operacao   operation to the counter (11 = hold)
//   valor      load value to the counter
//   ack        one-hot completion pulse to the granted requester
//   erro       pulses with ack when the request was rejected
//   ocupado    high whenever the FSM is not in IDLE
module arbitro_contador #(
  parameter int N_REQ = 4,
  parameter int W     = 6
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] op_req,
  input  logic [W*N_REQ-1:0] valor_req,
  input  logic [W-1:0]       cont,
  output logic [1:0]         operacao,
  output logic [W-1:0]       valor,
  output logic [N_REQ-1:0]   ack,
  output logic               erro,
  output logic               ocupado
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    ACK  = 2'b10
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [1:0]    op_win;
  logic [W-1:0]  val_win;
  logic          rej_win;
  logic [PW-1:0] win_p1;
  logic          rej_p1;

  // First set request bit searching upward from p, wrapping at N_REQ-1.
  // Scanning offsets from the farthest down to the nearest lets the
  // nearest hit overwrite any earlier one.
  function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [PW-1:0]    p);
    logic [PW-1:0] pick;
    logic [PW-1:0] idx;
    pick = p;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(p) + i) % N_REQ);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Guard against counter wrap-around.
  function automatic logic reject(input logic [1:0] op, input logic [W-1:0] c);
    return ((op == OP_INC) && (c == {W{1'b1}})) ||
           ((op == OP_DEC) && (c == {W{1'b0}}));
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] w);
    return (w == PW'(N_REQ - 1)) ? '0 : w + PW'(1);
  endfunction

  assign win     = rr_pick(req, ptr);
  assign op_win  = op_req[2*int'(win) +: 2];
  assign val_win = valor_req[W*int'(win) +: W];
  assign rej_win = reject(op_win, cont);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state    <= IDLE;
      operacao <= OP_HOLD;
      valor    <= '0;
      ack      <= '0;
      erro     <= 1'b0;
      ocupado  <= 1'b0;
      ptr      <= '0;
    end else begin
      case (state)
        // grant edge: latch winner and rejection, present the EXEC command
        IDLE: begin
          ack      <= '0;
          erro     <= 1'b0;
          operacao <= OP_HOLD;
          valor    <= '0;
          if (|req) begin
            win_p1   <= win;
            rej_p1   <= rej_win;
            operacao <= rej_win ? OP_HOLD : op_win;
            valor    <= (op_win == OP_LOAD) ? val_win : '0;
            ocupado  <= 1'b1;
            state    <= EXEC;
          end
        end
        // counter applies the command at the end of EXEC
        EXEC: begin
          operacao <= OP_HOLD;
          valor    <= '0;
          ack      <= {{(N_REQ-1){1'b0}}, 1'b1} << win_p1;
          erro     <= rej_p1;
          state    <= ACK;
        end
        // acknowledge cycle: advance the round-robin pointer past the winner
        ACK: begin
          ack     <= '0;
          erro    <= 1'b0;
          ocupado <= 1'b0;
          ptr     <= ptr_next(win_p1);
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_contador.sv
// Testbench for arbitro_contador: table-driven transactions with a
// scoreboard queue of expected ack/erro/cont, plus hand-written reset
// sequences. A behavioural counter closes the cont feedback loop.
module tb_arbitro_contador;

  localparam int N_REQ = 4;
  localparam int W     = 6;

  logic               clk;
  logic               clr_n;
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] op_req;
  logic [W*N_REQ-1:0] valor_req;
  logic [W-1:0]       cont;
  logic [1:0]         operacao;
  logic [W-1:0]       valor;
  logic [N_REQ-1:0]   ack;
  logic               erro;
  logic               ocupado;

  int n_tests = 0;
  int n_fail  = 0;

  arbitro_contador #(.N_REQ(N_REQ), .W(W)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .req       (req),
    .op_req    (op_req),
    .valor_req (valor_req),
    .cont      (cont),
    .operacao  (operacao),
    .valor     (valor),
    .ack       (ack),
    .erro      (erro),
    .ocupado   (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared counter, cleared by the same clr_n
  always @(posedge clk) begin
    if (!clr_n) cont <= '0;
    else begin
      case (operacao)
        2'b00:   cont <= cont + 6'd1;
        2'b01:   cont <= cont - 6'd1;
        2'b10:   cont <= valor;
        default: cont <= cont;
      endcase
    end
  end

  typedef struct {
    logic [3:0]  rq;
    logic [7:0]  op;
    logic [23:0] val;
    logic        drop;
    logic [3:0]  e_ack;
    logic        e_erro;
    logic [1:0]  e_op;
    logic [5:0]  e_valor;
    logic [5:0]  e_cont;
  } vec_t;

  typedef struct {
    logic [3:0] ack;
    logic       erro;
    logic [5:0] cont;
  } exp_t;

  exp_t sb[$];
  vec_t tv[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] opv(input int i, input logic [1:0] code);
    return 8'(code) << (2 * i);
  endfunction

  function automatic logic [23:0] vv(input int i, input int v);
    return 24'(v) << (6 * i);
  endfunction

  function automatic vec_t mk(input logic [3:0] rq, input logic [7:0] op,
                              input logic [23:0] val, input logic drop,
                              input logic [3:0] e_ack, input logic e_erro,
                              input logic [1:0] e_op, input int e_valor,
                              input int e_cont);
    vec_t v;
    v.rq = rq; v.op = op; v.val = val; v.drop = drop;
    v.e_ack = e_ack; v.e_erro = e_erro; v.e_op = e_op;
    v.e_valor = 6'(e_valor); v.e_cont = 6'(e_cont);
    return v;
  endfunction

  // Scoreboard: every ack is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (clr_n === 1'b1 && ack !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack", 32'(ack), 32'(e.ack));
        chk("erro", 32'(erro), 32'(e.erro));
        chk("cont_at_ack", 32'(cont), 32'(e.cont));
      end
    end else if (clr_n === 1'b1 && erro !== 1'b0) begin
      chk("erro_without_ack", 32'(erro), 32'd0);
    end
  end

  initial begin
    // contention: all inc from 0, served 0,1,2,3
    tv[0]  = mk(4'b1111, 8'h00, 24'h0, 1'b0, 4'b0001, 1'b0, 2'b00, 0, 1);
    tv[1]  = mk(4'b1111, 8'h00, 24'h0, 1'b0, 4'b0010, 1'b0, 2'b00, 0, 2);
    tv[2]  = mk(4'b1111, 8'h00, 24'h0, 1'b0, 4'b0100, 1'b0, 2'b00, 0, 3);
    tv[3]  = mk(4'b1111, 8'h00, 24'h0, 1'b0, 4'b1000, 1'b0, 2'b00, 0, 4);
    // 0 and 2 with ptr=0: 0 first, then pending 2
    tv[4]  = mk(4'b0101, 8'h00, 24'h0, 1'b1, 4'b0001, 1'b0, 2'b00, 0, 5);
    tv[5]  = mk(4'b0100, 8'h00, 24'h0, 1'b0, 4'b0100, 1'b0, 2'b00, 0, 6);
    // load 5, then single inc -> 6
    tv[6]  = mk(4'b0001, opv(0, 2'b10), vv(0, 5), 1'b1, 4'b0001, 1'b0, 2'b10, 5, 5);
    tv[7]  = mk(4'b0001, opv(0, 2'b00), 24'h0, 1'b0, 4'b0001, 1'b0, 2'b00, 0, 6);
    // load 63 then rejected inc
    tv[8]  = mk(4'b0010, opv(1, 2'b10), vv(1, 63), 1'b0, 4'b0010, 1'b0, 2'b10, 63, 63);
    tv[9]  = mk(4'b0010, opv(1, 2'b00), 24'h0, 1'b1, 4'b0010, 1'b1, 2'b11, 0, 63);
    // load 0 then rejected dec
    tv[10] = mk(4'b0100, opv(2, 2'b10), vv(2, 0), 1'b0, 4'b0100, 1'b0, 2'b10, 0, 0);
    tv[11] = mk(4'b0100, opv(2, 2'b01), 24'h0, 1'b0, 4'b0100, 1'b1, 2'b11, 0, 0);
    // ptr=3: requester 3 loads 42 ahead of requester 0 loading 7, ptr wraps
    tv[12] = mk(4'b1001, opv(3, 2'b10) | opv(0, 2'b10), vv(3, 42) | vv(0, 7), 1'b1,
                4'b1000, 1'b0, 2'b10, 42, 42);
    tv[13] = mk(4'b0001, opv(0, 2'b10), vv(0, 7), 1'b0, 4'b0001, 1'b0, 2'b10, 7, 7);
    // no-op with a nonzero value: hold, valor 0
    tv[14] = mk(4'b0010, opv(1, 2'b11), vv(1, 33), 1'b0, 4'b0010, 1'b0, 2'b11, 0, 7);
    // plain dec
    tv[15] = mk(4'b0100, opv(2, 2'b01), 24'h0, 1'b1, 4'b0100, 1'b0, 2'b01, 0, 6);

    // reset with all requests high
    clr_n = 1'b0; req = 4'b1111; op_req = 8'h00; valor_req = 24'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_operacao", 32'(operacao), 32'd3);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_erro", 32'(erro), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_valor", 32'(valor), 32'd0);

    for (int i = 0; i < 16; i++) begin
      exp_t e;
      clr_n = 1'b1;
      req = tv[i].rq; op_req = tv[i].op; valor_req = tv[i].val;
      e.ack = tv[i].e_ack; e.erro = tv[i].e_erro; e.cont = tv[i].e_cont;
      sb.push_back(e);
      @(negedge clk);
      chk($sformatf("v%0d_exec_operacao", i), 32'(operacao), 32'(tv[i].e_op));
      chk($sformatf("v%0d_exec_valor", i), 32'(valor), 32'(tv[i].e_valor));
      chk($sformatf("v%0d_exec_ocupado", i), 32'(ocupado), 32'd1);
      if (tv[i].drop) begin
        req = 4'b0000; op_req = 8'($urandom); valor_req = 24'($urandom);
      end
      @(negedge clk);
      chk($sformatf("v%0d_ack_ocupado", i), 32'(ocupado), 32'd1);
      chk($sformatf("v%0d_ack_operacao", i), 32'(operacao), 32'd3);
      @(negedge clk);
      chk($sformatf("v%0d_idle_ocupado", i), 32'(ocupado), 32'd0);
      chk($sformatf("v%0d_ack_arrived", i), 32'(sb.size()), 32'd0);
      sb.delete();
    end

    // reset during EXEC of requester 2
    req = 4'b0100; op_req = opv(2, 2'b00); valor_req = 24'h0;
    @(negedge clk);
    chk("abort_exec_operacao", 32'(operacao), 32'd0);
    clr_n = 1'b0; req = 4'b0000;
    @(negedge clk);
    chk("abort_ocupado", 32'(ocupado), 32'd0);
    chk("abort_operacao", 32'(operacao), 32'd3);
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_cont", 32'(cont), 32'd0);
    // after release the pointer must be back at 0
    begin
      exp_t e;
      clr_n = 1'b1; req = 4'b1111; op_req = 8'hFF; valor_req = 24'h0;
      e.ack = 4'b0001; e.erro = 1'b0; e.cont = 6'd0;
      sb.push_back(e);
    end
    @(negedge clk);
    chk("post_rst_ocupado", 32'(ocupado), 32'd1);
    chk("post_rst_operacao", 32'(operacao), 32'd3);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_ack_arrived", 32'(sb.size()), 32'd0);
    repeat (4) @(negedge clk);
    chk("final_ocupado", 32'(ocupado), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
